// File: rtl/context_scheduler.sv
// Round-robin time-slice scheduler that shares one core between NPROC resident programs.
// Define SCHED_PRIO_EN to add a per-slot priority bit (create_prio) that SELECT honours first.
module context_scheduler #(
  parameter int          NPROC   = 4,
  parameter int          PIDW    = 2,
  parameter int          QUANTUM = 11,
  parameter logic [31:0] OS_PC   = 32'h0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             create,
  input  logic [PIDW-1:0]  create_pid,
  input  logic [31:0]      create_pc,
`ifdef SCHED_PRIO_EN
  input  logic             create_prio,
`endif
  input  logic             retire,
  input  logic [31:0]      pc_now,
  input  logic             io_block,
  input  logic [NPROC-1:0] io_done,
  input  logic             exit,
  output logic             load_pc,
  output logic [31:0]      load_addr,
  output logic [PIDW-1:0]  cur_pid,
  output logic             running,
  output logic             in_os,
  output logic [NPROC-1:0] slot_busy
);
  typedef enum logic [1:0] {S_FREE, S_READY, S_RUNNING, S_BLOCKED} slot_e;
  typedef enum logic [2:0] {IDLE, SELECT, DISPATCH, RUN, SAVE} fsm_e;
  typedef enum logic [1:0] {R_EXIT, R_BLOCK, R_QUANT} why_e;

  fsm_e            state_q, state_d;
  why_e            why_q, why_d;
  slot_e           slot_q [NPROC];
  slot_e           slot_d [NPROC];
  logic [31:0]     spc_q  [NPROC];
  logic [31:0]     spc_d  [NPROC];
  logic [7:0]      cnt_q, cnt_d;
  logic [PIDW-1:0] rr_q, rr_d, cur_q, cur_d;
  logic            load_q, load_d;
  logic [31:0]     addr_q, addr_d;

  logic [NPROC-1:0] ready_v, cand_v;
  logic             found;
  logic [PIDW-1:0]  pick;

  // Scan rr+1, rr+2 ... rr; the descending loop lets the nearest candidate win.
  function automatic logic [PIDW:0] rr_pick(input logic [NPROC-1:0] cand,
                                            input logic [PIDW-1:0]  rr);
    logic [PIDW:0]   r;
    logic [PIDW-1:0] ix;
    int              idx;
    r = '0;
    for (int k = NPROC; k >= 1; k--) begin
      idx = int'(rr) + k;
      if (idx >= NPROC) idx = idx - NPROC;
      ix = PIDW'(idx);
      if (cand[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  for (genvar g = 0; g < NPROC; g++) begin : g_slot
    assign ready_v[g]   = (slot_q[g] == S_READY);
    assign slot_busy[g] = (slot_q[g] != S_FREE);
  end

`ifdef SCHED_PRIO_EN
  logic [NPROC-1:0] prio_q, prio_d;
  always_comb cand_v = (|(ready_v & prio_q)) ? (ready_v & prio_q) : ready_v;
`else
  always_comb cand_v = ready_v;
`endif

  assign {found, pick} = rr_pick(cand_v, rr_q);

  always_comb begin
    state_d = state_q;
    why_d   = why_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    cur_d   = cur_q;
    load_d  = 1'b0;
    addr_d  = addr_q;
`ifdef SCHED_PRIO_EN
    prio_d  = prio_q;
`endif
    // Slot-local events; their source states never overlap, so order is irrelevant.
    for (int i = 0; i < NPROC; i++) begin
      slot_d[i] = slot_q[i];
      spc_d[i]  = spc_q[i];
      if (slot_q[i] == S_BLOCKED && io_done[i]) slot_d[i] = S_READY;
      if (create && int'(create_pid) == i && slot_q[i] == S_FREE) begin
        slot_d[i] = S_READY;
        spc_d[i]  = create_pc;
`ifdef SCHED_PRIO_EN
        prio_d[i] = create_prio;
`endif
      end
    end

    case (state_q)
      IDLE: if (|ready_v) state_d = SELECT;
      SELECT: begin
        load_d = ~found;
        if (found) begin
          cur_d   = pick;
          addr_d  = spc_q[pick];
          load_d  = 1'b1;
          state_d = DISPATCH;
        end else begin
          addr_d  = OS_PC;
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        for (int i = 0; i < NPROC; i++)
          if (int'(cur_q) == i) slot_d[i] = S_RUNNING;
        rr_d    = cur_q;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (retire) cnt_d = cnt_q + 8'd1;
        if (exit) begin
          why_d = R_EXIT;   state_d = SAVE;
        end else if (io_block) begin
          why_d = R_BLOCK;  state_d = SAVE;
        end else if (retire && cnt_q == 8'(QUANTUM - 1)) begin
          why_d = R_QUANT;  state_d = SAVE;
        end
      end
      SAVE: begin
        for (int i = 0; i < NPROC; i++) begin
          if (int'(cur_q) == i) begin
            spc_d[i] = pc_now;
            case (why_q)
              R_EXIT:  slot_d[i] = S_FREE;
              R_BLOCK: slot_d[i] = io_done[i] ? S_READY : S_BLOCKED;
              default: slot_d[i] = S_READY;
            endcase
          end
        end
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      why_q   <= R_QUANT;
      cnt_q   <= '0;
      rr_q    <= PIDW'(NPROC - 1);
      cur_q   <= '0;
      load_q  <= 1'b0;
      addr_q  <= OS_PC;
      for (int i = 0; i < NPROC; i++) begin
        slot_q[i] <= S_FREE;
        spc_q[i]  <= '0;
      end
`ifdef SCHED_PRIO_EN
      prio_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      why_q   <= why_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      for (int i = 0; i < NPROC; i++) begin
        slot_q[i] <= slot_d[i];
        spc_q[i]  <= spc_d[i];
      end
`ifdef SCHED_PRIO_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign load_pc   = load_q;
  assign load_addr = addr_q;
  assign cur_pid   = cur_q;
  assign running   = (state_q == RUN);
  assign in_os     = ~running;
endmodule

// File: tb/tb_context_scheduler.sv
// Randomized scoreboard bench for context_scheduler: a slot-level model predicts every
// load_pc pulse (pid, address, busy mask, cycle); a negedge monitor pops and compares.
module tb_context_scheduler;
  localparam int          NPROC   = 4;
  localparam int          PIDW    = 2;
  localparam int          QUANTUM = 11;
  localparam logic [31:0] OS_PC   = 32'h0;
  localparam int FREE = 0, READY = 1, RUNNING = 2, BLOCKED = 3;
  localparam int K_QUANT = 0, K_EXIT = 1, K_BLOCK = 2;

  logic             CLK = 1'b0, reset = 1'b1;
  logic             create = 1'b0, retire = 1'b0, io_block = 1'b0, exit = 1'b0;
  logic [PIDW-1:0]  create_pid = '0;
  logic [31:0]      create_pc = '0, pc_now = '0;
  logic [NPROC-1:0] io_done = '0;
  logic             load_pc, running, in_os;
  logic [31:0]      load_addr;
  logic [PIDW-1:0]  cur_pid;
  logic [NPROC-1:0] slot_busy;
`ifdef SCHED_PRIO_EN
  logic             create_prio = 1'b0;
`endif

  context_scheduler #(.NPROC(NPROC), .PIDW(PIDW), .QUANTUM(QUANTUM), .OS_PC(OS_PC)) dut (
    .CLK(CLK), .reset(reset), .create(create), .create_pid(create_pid), .create_pc(create_pc),
`ifdef SCHED_PRIO_EN
    .create_prio(create_prio),
`endif
    .retire(retire), .pc_now(pc_now), .io_block(io_block), .io_done(io_done), .exit(exit),
    .load_pc(load_pc), .load_addr(load_addr), .cur_pid(cur_pid), .running(running),
    .in_os(in_os), .slot_busy(slot_busy));

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int               pid;
    logic [31:0]      addr;
    logic [NPROC-1:0] busy;
    bit               os;
    int               when;
  } exp_t;
  exp_t q[$];

  // Reference model: slot states, saved PCs, round-robin pointer.
  int          m_st [NPROC];
  logic [31:0] m_pc [NPROC];
  int          m_rr, m_cur;
  bit          m_run;
  int          rst_req = 0, timeouts = 0;

  function automatic void model_reset();
    for (int i = 0; i < NPROC; i++) begin m_st[i] = FREE; m_pc[i] = '0; end
    m_rr = NPROC - 1; m_cur = 0; m_run = 0;
    q.delete();
  endfunction

  function automatic void schedule(int stamp);
    exp_t e;
    int   p;
    p = -1;
    for (int k = 1; k <= NPROC; k++) begin
      int s;
      s = (m_rr + k) % NPROC;
      if (p < 0 && m_st[s] == READY) p = s;
    end
    if (p >= 0) begin
      m_st[p] = RUNNING; m_rr = p; m_cur = p; m_run = 1;
      e.os = 0; e.addr = m_pc[p];
    end else begin
      m_run = 0; e.os = 1; e.addr = OS_PC;
    end
    for (int i = 0; i < NPROC; i++) e.busy[i] = (m_st[i] != FREE);
    e.pid = m_cur; e.when = stamp + 3;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
    create = 0; retire = 0; io_block = 0; exit = 0; io_done = '0;
  endtask

  task automatic apply_reset();
    create = 0; retire = 0; io_block = 0; exit = 0; io_done = '0;
    reset = 1; @(posedge CLK); #1; reset = 0;
    model_reset();
    rst_req++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin tick(); n++; end
    if (q.size() != 0) begin timeouts++; q.delete(); end
  endtask

  // Create pulse this cycle; when nothing runs, the model expects a dispatch.
  task automatic do_create(input int pid, input logic [31:0] pc);
    create = 1; create_pid = PIDW'(pid); create_pc = pc;
    if (m_st[pid] == FREE) begin
      m_st[pid] = READY; m_pc[pid] = pc;
      if (!m_run) schedule(cyc);
    end
    tick();
  endtask

  task automatic do_done(input logic [NPROC-1:0] m);
    io_done = m;
    for (int i = 0; i < NPROC; i++) if (m[i] && m_st[i] == BLOCKED) m_st[i] = READY;
    if (!m_run && m != '0) schedule(cyc);
    tick();
  endtask

  // One slice of the running process ending by quantum, exit or io_block.
  task automatic run_slice(input int kind, input bit both, input bit dis, input logic [31:0] spc);
    int               nret, c, stamp;
    logic [NPROC-1:0] dm;
    nret = (kind == K_QUANT) ? QUANTUM - 1 : $urandom_range(0, QUANTUM - 1);
    c = 0;
    while (c < nret) begin
      pc_now = $urandom;
      if ($urandom_range(0, 3) != 0) begin retire = 1; c++; end
      if ($urandom_range(0, 7) == 0) begin
        int p;
        p = $urandom_range(0, NPROC - 1);
        io_done[p] = 1;
        if (m_st[p] == BLOCKED) m_st[p] = READY;
      end
      if ($urandom_range(0, 9) == 0) begin
        int p;
        p = $urandom_range(0, NPROC - 1);
        create = 1; create_pid = PIDW'(p); create_pc = $urandom & 32'hFFFF_FFFC;
        if (m_st[p] == FREE) begin m_st[p] = READY; m_pc[p] = create_pc; end
      end
      tick();
    end
    pc_now = spc;
    case (kind)
      K_QUANT: retire = 1;
      K_EXIT:  begin exit = 1; io_block = both | 1'($urandom_range(0, 1)); retire = 1'($urandom_range(0, 1)); end
      default: begin io_block = 1; retire = 1'($urandom_range(0, 1)); end
    endcase
    stamp = cyc;
    tick();
    pc_now = spc;
    dm = ($urandom_range(0, 3) == 0) ? NPROC'($urandom) : '0;
    dm[m_cur] = dis;
    io_done = dm;
    for (int i = 0; i < NPROC; i++) if (dm[i] && m_st[i] == BLOCKED) m_st[i] = READY;
    m_pc[m_cur] = spc;
    case (kind)
      K_EXIT:  m_st[m_cur] = FREE;
      K_BLOCK: m_st[m_cur] = dis ? READY : BLOCKED;
      default: m_st[m_cur] = READY;
    endcase
    tick();
    pc_now = $urandom;
    schedule(stamp);
    wait_drain();
  endtask

  // Monitor / checker: sole owner of the comparison counters.
  int n_chk = 0, n_pass = 0, rst_seen = 0, to_seen = 0;
  bit chk_run = 0, exp_run = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  always @(negedge CLK) begin
    if (rst_seen != rst_req) begin
      rst_seen++;
      chk_run = 0;
      chk("reset_load_pc",   32'(load_pc),   32'd0);
      chk("reset_load_addr", load_addr,      OS_PC);
      chk("reset_cur_pid",   32'(cur_pid),   32'd0);
      chk("reset_running",   32'(running),   32'd0);
      chk("reset_in_os",     32'(in_os),     32'd1);
      chk("reset_slot_busy", 32'(slot_busy), 32'd0);
    end else if (!reset) begin
      if (to_seen != timeouts) begin
        to_seen++; n_chk++;
        $display("FAIL drain_timeout: expected load_pc never seen (cycle %0d)", cyc);
      end
      if (chk_run) begin
        chk_run = 0;
        chk("running_after_load", 32'(running), 32'(exp_run));
        chk("in_os_after_load",   32'(in_os),   32'(!exp_run));
      end
      if (load_pc) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_load_pc: got addr %0h pid %0d expected none (cycle %0d)",
                   load_addr, cur_pid, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("load_cycle", 32'(cyc),      32'(e.when));
          chk("load_addr",  load_addr,     e.addr);
          chk("cur_pid",    32'(cur_pid),   32'(e.pid));
          chk("slot_busy",  32'(slot_busy), 32'(e.busy));
          chk_run = 1; exp_run = !e.os;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    apply_reset();
    // Create into an empty system, then sole process exits back to the OS.
    do_create(1, 32'h100);
    wait_drain();
    run_slice(K_EXIT, 0, 0, 32'h1234);
    // Quantum rotation between pids 0 and 1.
    apply_reset();
    do_create(0, 32'h40);
    wait_drain();
    do_create(1, 32'h80);
    run_slice(K_QUANT, 0, 0, 32'h6C);
    run_slice(K_QUANT, 0, 0, 32'h90);
    // Block pid 0, wake it while pid 1 runs, resume at 0x50.
    run_slice(K_BLOCK, 0, 0, 32'h50);
    do_done(4'b0001);
    run_slice(K_QUANT, 0, 0, 32'hA0);
    // Exit beats io_block; io_done during SAVE readies a blocking slot.
    run_slice(K_EXIT, 1, 0, 32'h60);
    run_slice(K_BLOCK, 0, 1, 32'h70);
    run_slice(K_QUANT, 0, 0, 32'h74);
    // Reset mid-slice, then a fresh slice must run a full quantum.
    repeat (5) begin retire = 1; tick(); end
    apply_reset();
    do_create(2, 32'h200);
    wait_drain();
    run_slice(K_QUANT, 0, 0, 32'h220);
    // Random phase.
    for (int it = 0; it < 200; it++) begin
      if (m_run) begin
        run_slice($urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
      end else begin
        int p, nfree, nblk;
        nfree = 0; nblk = 0;
        for (int i = 0; i < NPROC; i++) begin
          if (m_st[i] == FREE) nfree++;
          if (m_st[i] == BLOCKED) nblk++;
        end
        p = $urandom_range(0, NPROC - 1);
        if (nblk > 0 && (nfree == 0 || $urandom_range(0, 1) == 0)) begin
          while (m_st[p] != BLOCKED) p = (p + 1) % NPROC;
          do_done(NPROC'(1) << p);
        end else begin
          do_create(p, $urandom & 32'hFFFF_FFFC);
        end
        wait_drain();
      end
    end
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/context_scheduler.md
Name: context_scheduler

Overview:
- Round-robin time-slice scheduler that shares the single MIPS core between up to NPROC resident programs.
- Holds a saved PC and a state per process slot.
- Counts retired instructions against a quantum, parks processes blocked on I/O, and drives the PC load port to dispatch the next process or return to the OS entry point.
- Sits beside the PC/fetch stage; the OS loader creates processes and the I/O unit wakes them.

Parameters:
- NPROC, 4, number of process slots (2..8)
- PIDW, 2, width of the process id (clog2 of NPROC)
- QUANTUM, 11, instructions retired per time slice before forced switch (1..255)
- OS_PC, 32'h0, OS entry address loaded when no process is runnable

Ports:
- CLK  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- create  input  1  one-cycle pulse: register a new process
- create_pid  input  PIDW  slot for new process
- create_pc  input  32  start address of new process
- retire  input  1  running process retired one instruction this cycle
- pc_now  input  32  PC value to resume the running process from
- io_block  input  1  running process issued an input/output request and must block
- io_done  input  NPROC  per-slot I/O completion, one-cycle pulses
- exit  input  1  running process terminated
- load_pc  output  1  one-cycle pulse: PC must load load_addr
- load_addr  output  32  address to load
- cur_pid  output  PIDW  slot of running or last-dispatched process
- running  output  1  a process owns the core
- in_os  output  1  core is in OS/scheduler context (equals !running)
- slot_busy  output  NPROC  slot i is not FREE

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high.
- Reset values: all slots FREE; FSM IDLE; load_pc 0; load_addr OS_PC; cur_pid 0; running 0; in_os 1; slot_busy 0; quantum counter 0; rr pointer NPROC-1.
- Slot states: FREE, READY, RUNNING, BLOCKED. Each slot has a saved_pc[31:0].
- create (any FSM state):
  - Target slot FREE: it becomes READY with saved_pc = create_pc.
  - Target slot not FREE: create is ignored.
- io_done[i]: BLOCKED -> READY. Ignored for slots in any other state.
- FSM:
  - IDLE: if any slot is READY, go to SELECT; otherwise stay.
  - SELECT (1 cycle):
    - Scan slots rr+1, rr+2 … wrapping, rr last, for the first READY slot.
    - Found: go to DISPATCH.
    - None found: go to IDLE and pulse load_pc with load_addr = OS_PC.
  - DISPATCH (1 cycle):
    - load_pc = 1, load_addr = saved_pc[sel], cur_pid = sel.
    - Slot sel becomes RUNNING; rr = sel; counter = 0; go to RUN.
  - RUN:
    - running = 1; in_os = 0.
    - retire increments the counter.
    - Exit triggers, priority exit > io_block > quantum. Quantum triggers when retire and counter == QUANTUM-1.
    - On a trigger go to SAVE and latch the reason.
    - retire is ignored outside RUN.
  - SAVE (1 cycle):
    - saved_pc[cur_pid] = pc_now.
    - Slot becomes FREE (exit), BLOCKED (io_block) or READY (quantum).
    - If io_done[cur_pid] is asserted in the SAVE cycle, a blocking slot becomes READY instead.
    - Go to SELECT.
- Latency:
  - Trigger in RUN cycle T: SAVE at T+1, SELECT at T+2, load_pc at T+3 (DISPATCH), running high from T+4.
  - create into empty system at cycle C: load_pc at C+3.
- A sole READY process whose quantum expires re-selects itself: same pid, load_addr = its pc_now.
- running and in_os reflect the FSM state registered at that edge; running is 0 in SAVE, SELECT and DISPATCH.
- Counter is 8 bits, cleared on dispatch, never wraps within a slice.
- Reset mid-operation: all state returns to reset values on that edge; any in-flight SAVE is discarded.

Optional Feature:
- Macro: SCHED_PRIO_EN.
- Defined:
  - Adds input create_prio (1 bit), stored per slot at create.
  - SELECT picks a high-priority READY slot first, round-robin among high-priority slots, and falls back to low-priority round-robin.
  - Adds a 1-cycle-latency-free rule: a high-priority slot becoming READY does not preempt; it waits for the current slice to end.
- Undefined: create_prio port absent; pure round-robin as above.

Test Plan:
- reset, create pid 1 pc 0x100 at cycle 0 -> load_pc=1, load_addr=0x100, cur_pid=1 at cycle 3; running=1 at cycle 4.
- pids 0 (0x40) and 1 (0x80) created; 11 retires on pid 0 with pc_now=0x6C -> switch to pid 1 (load_addr 0x80); after pid 1 quantum, pid 0 dispatched with load_addr 0x6C.
- pid 0 running, io_block with pc_now=0x50, pid 1 READY -> pid 1 dispatched; io_done[0] -> slot 0 READY; at pid 1 quantum end pid 0 resumes at 0x50.
- sole process exits -> load_pc with load_addr=OS_PC, in_os=1, running=0, slot_busy=0, FSM IDLE.
- exit and io_block same cycle -> slot FREE (exit wins); io_done in SAVE cycle of io_block -> slot READY, not BLOCKED.
- reset asserted during RUN mid-slice -> next edge all outputs at reset values, slot_busy=0; create afterwards dispatches with counter restarted at 0.
